// File: rtl/screen_seq_ctl.sv
// -----------------------------------------------------------------------------
// screen_seq_ctl
//
// Screen sequencing controller for a menu-driven game. Mouse clicks on the
// menu and a debounced board pushbutton raise mode requests. A request is
// parked in a one-entry pending register and only committed to `mode` at the
// next vertical-blank rising edge, so a screen change never tears a frame.
// The menu also owns the difficulty bit and a 7-entry colour palette index.
//
// Ports
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous reset, active low
//   mouse_left   in   left mouse button level, synchronous to clk
//   button       in   raw board pushbutton, asynchronous and bouncing
//   xpos, ypos   in   [11:0] mouse position in pixels, synchronous to clk
//   vblnk_in     in   vertical blank; rising edge marks the frame boundary
//   mode         out  [1:0] committed screen: 00 MENU, 01 GAME, 10 CREDITS
//   difficulty   out  difficulty bit
//   color_state  out  [2:0] palette index 0..6
//   color1/2     out  [11:0] palette colours for color_state
//   game_start   out  one-cycle pulse on the first cycle mode reads GAME
// -----------------------------------------------------------------------------
module screen_seq_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned X_MIN           = 362,
  parameter int unsigned X_MAX           = 674
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic        button,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        vblnk_in,
  output logic [1:0]  mode,
  output logic        difficulty,
  output logic [2:0]  color_state,
  output logic [11:0] color1,
  output logic [11:0] color2,
  output logic        game_start
);

  typedef enum logic [1:0] {
    MODE_MENU    = 2'b00,
    MODE_GAME    = 2'b01,
    MODE_CREDITS = 2'b10
  } mode_e;

  // The counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic in_range(input logic [11:0] v,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // ---------------------------------------------------------------------------
  // Click detection and hit testing
  // ---------------------------------------------------------------------------
  logic mouse_prev;
  logic click;
  logic x_hit;
  logic hit_play, hit_diff, hit_color, hit_credits;

  // mouse_prev resets to 1 so a button held through reset release is not
  // mistaken for a fresh press.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mouse_prev <= 1'b1;
    else      mouse_prev <= mouse_left;
  end

  assign click       = mouse_left & ~mouse_prev;
  assign x_hit       = in_range(xpos, 12'(X_MIN), 12'(X_MAX));
  assign hit_play    = click & x_hit & in_range(ypos, 12'd46,  12'd146);
  assign hit_diff    = click & x_hit & in_range(ypos, 12'd238, 12'd338);
  assign hit_color   = click & x_hit & in_range(ypos, 12'd430, 12'd530);
  assign hit_credits = click & x_hit & in_range(ypos, 12'd622, 12'd722);

  // ---------------------------------------------------------------------------
  // Frame boundary
  // ---------------------------------------------------------------------------
  logic vblnk_prev;
  logic frame_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vblnk_prev <= 1'b0;
    else      vblnk_prev <= vblnk_in;
  end

  assign frame_start = vblnk_in & ~vblnk_prev;

  // ---------------------------------------------------------------------------
  // Pushbutton synchroniser, debouncer and rising-edge pulse
  // ---------------------------------------------------------------------------
  logic             btn_sync1, btn_sync2;
  logic             btn_db, btn_db_d;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_db    <= 1'b0;
      btn_db_d  <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_sync1 <= button;
      btn_sync2 <= btn_sync1;
      btn_db_d  <= btn_db;
      // Any cycle that agrees with the current level restarts the count.
      if (btn_sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        btn_db <= btn_sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign btn_pulse = btn_db & ~btn_db_d;

  // ---------------------------------------------------------------------------
  // Mode sequencer: committed mode, pending request, menu settings
  // ---------------------------------------------------------------------------
  mode_e      mode_q, mode_d;
  logic       pend_valid_q, pend_valid_d;
  mode_e      pend_tgt_q, pend_tgt_d;
  logic       diff_q, diff_d;
  logic [2:0] color_q, color_d;
  logic       start_q, start_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_MENU;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= MODE_MENU;
      diff_q       <= 1'b0;
      color_q      <= 3'd0;
      start_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      diff_q       <= diff_d;
      color_q      <= color_d;
      start_q      <= start_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the branches below can leave a variable unassigned (no latch).
    mode_d       = mode_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    diff_d       = diff_q;
    color_d      = color_q;
    start_d      = 1'b0;

    if (pend_valid_q) begin
      // A pending request blocks all new requests and menu edits; it only
      // leaves through a frame boundary.
      if (frame_start) begin
        mode_d       = pend_tgt_q;
        pend_valid_d = 1'b0;
        start_d      = (pend_tgt_q == MODE_GAME);
      end
    end else if (mode_q == MODE_MENU) begin
      if (hit_play) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = MODE_GAME;
      end else if (hit_credits) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = MODE_CREDITS;
      end else if (hit_diff) begin
        diff_d = ~diff_q;
      end else if (hit_color) begin
        color_d = (color_q >= 3'd6) ? 3'd0 : color_q + 3'd1;
      end
    end else if (btn_pulse) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = MODE_MENU;
    end

    // Index 7 has no palette entry; recover to 0 whatever else is going on.
    if (color_q == 3'd7) color_d = 3'd0;
  end

  assign mode        = mode_q;
  assign difficulty  = diff_q;
  assign color_state = color_q;
  assign game_start  = start_q;

  // ---------------------------------------------------------------------------
  // Palette decode
  // ---------------------------------------------------------------------------
  always_comb begin
    color1 = 12'h000;
    color2 = 12'hFFF;
    case (color_q)
      3'd1: begin color1 = 12'h099; color2 = 12'hF66; end
      3'd2: begin color1 = 12'h909; color2 = 12'h6F6; end
      3'd3: begin color1 = 12'h990; color2 = 12'h66F; end
      3'd4: begin color1 = 12'h009; color2 = 12'hFF6; end
      3'd5: begin color1 = 12'h900; color2 = 12'h6FF; end
      3'd6: begin color1 = 12'h090; color2 = 12'hF6F; end
      default: begin color1 = 12'h000; color2 = 12'hFFF; end
    endcase
  end

endmodule

// File: tb/tb_screen_seq_ctl.sv
// -----------------------------------------------------------------------------
// tb_screen_seq_ctl
//
// Directed bench for screen_seq_ctl with a short debounce window. A
// frame-level model tracks what mode, difficulty, palette and game_start must
// be after every clock; the main process compares the DUT against it each
// cycle and adds hand-computed literal checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_screen_seq_ctl;

  localparam int DB = 8;

  logic        clk;
  logic        rst;
  logic        mouse_left;
  logic        button;
  logic [11:0] xpos, ypos;
  logic        vblnk_in;
  logic [1:0]  mode;
  logic        difficulty;
  logic [2:0]  color_state;
  logic [11:0] color1, color2;
  logic        game_start;

  int n_pass  = 0;
  int n_total = 0;
  int pulse_cnt = 0;

  screen_seq_ctl #(
    .DEBOUNCE_CYCLES(DB),
    .X_MIN(362),
    .X_MAX(674)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mouse_left(mouse_left),
    .button(button),
    .xpos(xpos),
    .ypos(ypos),
    .vblnk_in(vblnk_in),
    .mode(mode),
    .difficulty(difficulty),
    .color_state(color_state),
    .color1(color1),
    .color2(color2),
    .game_start(game_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Palette table as listed for the display.
  logic [11:0] pal1 [0:7] = '{12'h000, 12'h099, 12'h909, 12'h990,
                              12'h009, 12'h900, 12'h090, 12'h000};
  logic [11:0] pal2 [0:7] = '{12'hFFF, 12'hF66, 12'h6F6, 12'h66F,
                              12'hFF6, 12'h6FF, 12'hF6F, 12'hFFF};

  // ---------------------------------------------------------------------------
  // Behavioural model. The button path is a 2-sample delay followed by a
  // sliding window: the level flips once the last DB delayed samples all
  // disagree with it.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]    mode;
    logic          pv;
    logic [1:0]    pt;
    logic          diff;
    logic [2:0]    color;
    logic          gs;
    logic          mprev;
    logic          vprev;
    logic          s1;
    logic          s2;
    logic          db;
    logic          db_d;
    logic [DB-1:0] hist;
    logic [4:0]    hist_n;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r       = '0;
    r.mprev = 1'b1;
    return r;
  endfunction

  function automatic logic on_row(input logic [11:0] y, input int lo);
    return (int'(y) >= lo) && (int'(y) <= lo + 100);
  endfunction

  function automatic model_t model_step(input model_t c, input logic ml,
                                        input logic btn, input logic [11:0] x,
                                        input logic [11:0] y, input logic vb);
    model_t n;
    logic click, bnd, pulse, xin;
    n     = c;
    click = ml && !c.mprev;
    bnd   = vb && !c.vprev;
    pulse = c.db && !c.db_d;
    xin   = (int'(x) >= 362) && (int'(x) <= 674);
    n.gs  = 1'b0;
    if (c.pv) begin
      if (bnd) begin
        n.mode = c.pt;
        n.pv   = 1'b0;
        n.gs   = (c.pt == 2'd1);
      end
    end else if (c.mode == 2'd0) begin
      if (click && xin) begin
        if (on_row(y, 46))       begin n.pv = 1'b1; n.pt = 2'd1; end
        else if (on_row(y, 622)) begin n.pv = 1'b1; n.pt = 2'd2; end
        else if (on_row(y, 238)) n.diff  = !c.diff;
        else if (on_row(y, 430)) n.color = (c.color == 3'd6) ? 3'd0 : c.color + 3'd1;
      end
    end else if (pulse) begin
      n.pv = 1'b1;
      n.pt = 2'd0;
    end
    n.db_d   = c.db;
    n.hist   = {c.hist[DB-2:0], c.s2};
    n.hist_n = (int'(c.hist_n) < DB) ? c.hist_n + 5'd1 : c.hist_n;
    if (int'(n.hist_n) == DB && (c.db ? (n.hist == '0) : (n.hist == '1))) begin
      n.db     = !c.db;
      n.hist_n = '0;
    end
    n.s2    = c.s1;
    n.s1    = btn;
    n.mprev = ml;
    n.vprev = vb;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, mouse_left, button, xpos, ypos, vblnk_in);
  end

  always @(posedge clk) begin
    if (dut.btn_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("mode",        32'(mode),        32'(m.mode));
    check("difficulty",  32'(difficulty),  32'(m.diff));
    check("color_state", 32'(color_state), 32'(m.color));
    check("color1",      32'(color1),      32'(pal1[m.color]));
    check("color2",      32'(color2),      32'(pal2[m.color]));
    check("game_start",  32'(game_start),  32'(m.gs));
  endtask

  // Advance n cycles; inputs change 1 time unit after the edge and outputs
  // are compared against the model at the same point.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic click_at(input int x, input int y);
    xpos       = 12'(x);
    ypos       = 12'(y);
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    tick(1);
  endtask

  task automatic frame();
    vblnk_in = 1'b1;
    tick(2);
    vblnk_in = 1'b0;
    tick(2);
  endtask

  task automatic press_button();
    button = 1'b1;
    tick(2 + DB + 5);
    button = 1'b0;
    tick(2 + DB + 5);
  endtask

  initial begin
    rst        = 1'b0;
    mouse_left = 1'b0;
    button     = 1'b0;
    xpos       = '0;
    ypos       = '0;
    vblnk_in   = 1'b0;
    tick(3);
    check("rst_mode",   32'(mode),        32'd0);
    check("rst_diff",   32'(difficulty),  32'd0);
    check("rst_color",  32'(color_state), 32'd0);
    check("rst_c1",     32'(color1),      32'h000);
    check("rst_start",  32'(game_start),  32'd0);
    rst = 1'b1;
    tick(2);

    // Misses: just left of the column, between rows, just right of the column.
    click_at(361, 100);
    click_at(400, 200);
    click_at(675, 300);
    frame();
    check("miss_mode", 32'(mode), 32'd0);
    check("miss_diff", 32'(difficulty), 32'd0);

    // PLAY click then a frame boundary.
    click_at(400, 100);
    vblnk_in = 1'b1;
    tick(1);
    check("play_mode", 32'(mode), 32'd1);
    check("play_start_hi", 32'(game_start), 32'd1);
    tick(1);
    check("play_start_lo", 32'(game_start), 32'd0);
    vblnk_in = 1'b0;
    tick(2);
    check("play_diff", 32'(difficulty), 32'd0);
    check("play_color", 32'(color_state), 32'd0);

    // Bouncing button in GAME, then held: one pulse, MENU after the frame.
    repeat (5) begin
      button = 1'b1;
      tick(2);
      button = 1'b0;
      tick(2);
    end
    check("bounce_no_pulse", 32'(pulse_cnt), 32'd0);
    button = 1'b1;
    tick(20);
    check("bounce_one_pulse", 32'(pulse_cnt), 32'd1);
    check("bounce_mode_hold", 32'(mode), 32'd1);
    frame();
    check("bounce_mode_menu", 32'(mode), 32'd0);
    button = 1'b0;
    tick(20);
    check("release_no_pulse", 32'(pulse_cnt), 32'd1);

    // Held mouse on DIFF toggles once; a fresh press toggles back.
    xpos = 12'd500;
    ypos = 12'd300;
    mouse_left = 1'b1;
    tick(100);
    check("hold_diff", 32'(difficulty), 32'd1);
    mouse_left = 1'b0;
    tick(2);
    mouse_left = 1'b1;
    tick(2);
    check("repress_diff", 32'(difficulty), 32'd0);
    mouse_left = 1'b0;
    tick(2);

    // Seven COLOR clicks at the corner of the region.
    for (int i = 1; i <= 7; i++) begin
      click_at(362, 430);
      check("color_seq", 32'(color_state), 32'(i % 7));
      if (i == 1) begin
        check("color1_first", 32'(color1), 32'h099);
        check("color2_first", 32'(color2), 32'hF66);
      end
    end

    // First request wins; later clicks in the window are ignored.
    click_at(400, 46);
    click_at(674, 722);
    click_at(400, 238);
    check("pend_diff", 32'(difficulty), 32'd0);
    check("pend_mode", 32'(mode), 32'd0);
    frame();
    check("first_wins", 32'(mode), 32'd1);
    frame();
    check("credits_dropped", 32'(mode), 32'd1);

    // GAME -> MENU -> CREDITS; clicks in CREDITS do nothing; button back.
    press_button();
    frame();
    check("back_menu", 32'(mode), 32'd0);
    click_at(400, 622);
    frame();
    check("credits_mode", 32'(mode), 32'd2);
    click_at(400, 300);
    check("credits_diff", 32'(difficulty), 32'd0);
    press_button();
    frame();
    check("credits_exit", 32'(mode), 32'd0);

    // Request captured in a boundary cycle commits one frame later.
    xpos       = 12'd400;
    ypos       = 12'd100;
    mouse_left = 1'b1;
    vblnk_in   = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    tick(1);
    check("bnd_capture_wait", 32'(mode), 32'd0);
    vblnk_in = 1'b0;
    tick(2);
    frame();
    check("bnd_capture_commit", 32'(mode), 32'd1);
    press_button();
    frame();
    check("bnd_back_menu", 32'(mode), 32'd0);

    // Reset with a pending GAME request and the mouse held down.
    click_at(400, 100);
    xpos       = 12'd400;
    ypos       = 12'd300;
    mouse_left = 1'b1;
    button     = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(3);
    rst    = 1'b1;
    button = 1'b0;
    tick(5);
    frame();
    frame();
    check("rst_pend_mode", 32'(mode), 32'd0);
    check("rst_held_diff", 32'(difficulty), 32'd0);
    mouse_left = 1'b0;
    tick(1);
    mouse_left = 1'b1;
    tick(1);
    check("rst_fresh_click", 32'(difficulty), 32'd1);
    mouse_left = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/screen_seq_ctl.md
SCREEN_SEQ_CTL -- requirements
Module: screen_seq_ctl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 650000, consecutive stable cycles before the debounced button changes (10 ms at 65 MHz).
REQ-002 Parameter X_MIN, default 362, and X_MAX, default 674; inclusive horizontal bounds shared by all menu buttons.
REQ-003 clk  in  1  system clock; every register SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 mouse_left  in  1  left-button level, already synchronous to clk.
REQ-006 button  in  1  raw board pushbutton, asynchronous, bouncing.
REQ-007 xpos, ypos  in  12 each  mouse position in pixels, synchronous to clk.
REQ-008 vblnk_in  in  1  vertical blank; its rising edge is the frame boundary.
REQ-009 mode  out  2  committed screen: 00 MENU, 01 GAME, 10 CREDITS; 11 never driven.
REQ-010 difficulty  out  1  current difficulty bit.
REQ-011 color_state  out  3  palette index, 0..6.
REQ-012 color1, color2  out  12 each  palette colours for color_state.
REQ-013 game_start  out  1  one-cycle pulse on the cycle mode becomes GAME.

Function
REQ-014 Click SHALL be a 1-cycle pulse on a 0->1 transition of mouse_left (registered previous value); holding mouse_left SHALL NOT generate further clicks.
REQ-015 xpos and ypos SHALL be sampled in the same cycle as the click pulse; all regions are inclusive with x in [X_MIN, X_MAX]; y regions: PLAY 46..146, DIFF 238..338, COLOR 430..530, CREDITS 622..722.
REQ-016 button SHALL pass through a 2-FF synchronizer; debounced level btn_db SHALL change only after the synchronized value differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any return to btn_db restarts the count.
REQ-017 btn_pulse SHALL be a 1-cycle pulse on each 0->1 transition of btn_db; the total input-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-018 Mode requests are held in a pending register (valid flag plus 2-bit target) and SHALL NOT change mode directly.
REQ-019 In MENU with no pending request: a click in PLAY SHALL set pending = GAME; a click in CREDITS SHALL set pending = CREDITS.
REQ-020 In GAME or CREDITS with no pending request: btn_pulse SHALL set pending = MENU; clicks SHALL NOT set a request.
REQ-021 While a request is pending, new requests SHALL be ignored; the first request wins.
REQ-022 A frame-boundary cycle that starts with a valid pending request SHALL copy the target to mode and clear pending; mode changes on the next clock edge.
REQ-023 A request captured in a frame-boundary cycle SHALL commit at the following boundary, not the current one.
REQ-024 game_start SHALL assert for exactly the one cycle in which mode first reads 01 after a commit.
REQ-025 In MENU with no pending request, a click in DIFF SHALL toggle difficulty once, effective on the next cycle.
REQ-026 In MENU with no pending request, a click in COLOR SHALL advance color_state by 1, wrapping 6 -> 0; a value of 7 SHALL be forced to 0 on the next cycle.
REQ-027 difficulty and color_state SHALL hold in GAME and CREDITS, and SHALL hold while a request is pending.
REQ-028 color1/color2 SHALL be decoded combinationally from color_state:
  0: 000/FFF
  1: 099/F66
  2: 909/6F6
  3: 990/66F
  4: 009/FF6
  5: 900/6FF
  6: 090/F6F
  other: 000/FFF
REQ-029 A click outside every region, or one whose position is on no region row, SHALL have no effect.

Reset
REQ-030 While rst=0: mode=00, difficulty=0, color_state=0, game_start=0, pending cleared, debounce counter 0, btn_db=0, synchronizer regs 0.
REQ-031 The previous-mouse register SHALL reset to 1, so a mouse_left held through reset release generates no click until it is released and pressed again.
REQ-032 Reset asserted mid-debounce or with a request pending SHALL discard the pending request and the count; no commit follows reset release.

Verification
REQ-033 MENU, click at (400,100), then a vblnk_in rising edge -> mode=01 one cycle after the boundary cycle, game_start high for 1 cycle, difficulty and color unchanged.
REQ-034 MENU, hold mouse_left for 100 cycles at (500,300) -> difficulty toggles exactly once; release and press again -> toggles back to 0.
REQ-035 MENU, seven clicks at (362,430) -> color_state sequence 1..6,0; color1/color2=099/F66 after the first click.
REQ-036 GAME, button bounces 5 times in under DEBOUNCE_CYCLES, then held stable -> exactly one btn_pulse; mode=00 after the next frame boundary.
REQ-037 MENU, click PLAY then click CREDITS before the boundary -> mode=01 commits; the CREDITS request is dropped; a DIFF click in the same window does not toggle difficulty.
REQ-038 Pending GAME request, rst pulsed low for 3 cycles, mouse_left held high -> after release mode stays 00 across boundaries and no click occurs until mouse_left goes 0->1.
